ysyx_25040105_ifu: RTL and testbench

Instruction fetch unit for the ysyx_25040105 single-issue core. Holds the PC, issues one instruction-memory read at a time over a valid/ready request channel, and presents the fetched 32-bit word with its PC to the decode stage over a valid/ready handoff. Accepts PC redirects from branch/jump resolution and a sticky halt from the system-instruction path.

---
 rtl/ysyx_25040105_ifu.sv | 199 +++++++++++++++++++
 tb/tb_ysyx_25040105_ifu.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040105_ifu.sv
// Instruction fetch unit: PC, one-outstanding imem request channel, decode handoff.
// Optional performance counters are enabled by defining YSYX_25040105_IFU_PERF_EN.
module ysyx_25040105_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt
`ifdef YSYX_25040105_IFU_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic        halt_q, halt_d;
    logic        req_valid_q, req_valid_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_fault_q, inst_fault_d;

    logic req_hs;
    logic redir;
    logic halt_now;

    assign req_hs   = req_valid_q & imem_req_ready;
    assign redir    = redirect_valid & ~halt_q;
    assign halt_now = halt | halt_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        discard_d    = discard_q;
        halt_d       = halt_q | halt;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_fault_d = inst_fault_q;

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                // An accepted request always owes us a response, so squashing it means WAIT+discard.
                if (redir) begin
                    pc_d = redirect_pc;
                    if (req_hs) begin
                        discard_d = 1'b1;
                        state_d   = S_WAIT;
                    end
                end else if (halt_now) begin
                    if (req_hs) begin
                        discard_d = 1'b1;
                        state_d   = S_WAIT;
                    end else begin
                        state_d = S_HALT;
                    end
                end else if (pc_q[1:0] != 2'b00) begin
                    inst_d       = 32'h0;
                    inst_fault_d = 1'b1;
                    inst_pc_d    = pc_q;
                    state_d      = S_HOLD;
                end else if (req_hs) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redir) begin
                    pc_d = redirect_pc;
                    if (imem_rsp_valid) begin
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else begin
                        discard_d = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (discard_q || halt_now) begin
                        discard_d = 1'b0;
                        state_d   = halt_now ? S_HALT : S_REQ;
                    end else begin
                        inst_d       = imem_rsp_err ? 32'h0 : imem_rsp_data;
                        inst_fault_d = imem_rsp_err;
                        inst_pc_d    = pc_q;
                        state_d      = S_HOLD;
                    end
                end else if (halt) begin
                    discard_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redir) begin
                    pc_d    = redirect_pc;
                    state_d = S_REQ;
                end else if (halt_now) begin
                    state_d = S_HALT;
                end else if (inst_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_REQ;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next-state view so they line up with state_q.
        req_valid_d  = (state_d == S_REQ) && (pc_d[1:0] == 2'b00) && !halt_d;
        req_addr_d   = pc_d;
        inst_valid_d = (state_d == S_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            discard_q    <= 1'b0;
            halt_q       <= 1'b0;
            req_valid_q  <= 1'b0;
            req_addr_q   <= RESET_PC;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'h0;
            inst_pc_q    <= 32'h0;
            inst_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            discard_q    <= discard_d;
            halt_q       <= halt_d;
            req_valid_q  <= req_valid_d;
            req_addr_q   <= req_addr_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_fault_q <= inst_fault_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = req_addr_q;
    assign inst_valid     = inst_valid_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign inst_fault     = inst_fault_q;

`ifdef YSYX_25040105_IFU_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (state_q != S_HALT) begin
            if (inst_valid_q && inst_ready) begin
                fetch_cnt_d = fetch_cnt_q + 32'd1;
            end
            if (state_q == S_REQ || state_q == S_WAIT) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_25040105_ifu.sv
// Directed self-checking bench for ysyx_25040105_ifu; define YSYX_25040105_IFU_PERF_EN
// to also check the performance counters.
module tb_ysyx_25040105_ifu;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
`ifdef YSYX_25040105_IFU_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    ysyx_25040105_ifu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt)
`ifdef YSYX_25040105_IFU_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; imem_rsp_err = 1'b0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
        step(); step();
        total_cnt++;
        if ({imem_req_valid, inst_valid, inst_fault} !== 3'b000) $display("[TB] FAIL reset_valids: got %b want 000", {imem_req_valid, inst_valid, inst_fault});
        else pass_cnt++;
        total_cnt++;
        if (imem_req_addr !== 32'h8000_0000) $display("[TB] FAIL reset_addr: got %h want 80000000", imem_req_addr);
        else pass_cnt++;
        total_cnt++;
        if ({inst, inst_pc} !== 64'h0) $display("[TB] FAIL reset_inst: got inst=%h pc=%h want 0/0", inst, inst_pc);
        else pass_cnt++;
`ifdef YSYX_25040105_IFU_PERF_EN
        total_cnt++;
        if ({perf_fetch_cnt, perf_stall_cnt} !== 64'h0) $display("[TB] FAIL reset_perf: got %h/%h want 0/0", perf_fetch_cnt, perf_stall_cnt);
        else pass_cnt++;
`endif
        rst_n = 1'b1;
        step();
        total_cnt++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) $display("[TB] FAIL first_req: got v=%b a=%h want 1/80000000", imem_req_valid, imem_req_addr);
        else pass_cnt++;
    endtask

    task automatic test_basic_fetch();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        total_cnt++;
        if (imem_req_valid !== 1'b0) $display("[TB] FAIL wait_req_low: got %b want 0", imem_req_valid);
        else pass_cnt++;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
        step();
        imem_rsp_valid = 1'b0;
        total_cnt++;
        if (inst_valid !== 1'b1 || inst !== 32'h0000_0013 || inst_pc !== 32'h8000_0000 || inst_fault !== 1'b0)
            $display("[TB] FAIL basic_inst: got v=%b i=%h pc=%h f=%b want 1/00000013/80000000/0", inst_valid, inst, inst_pc, inst_fault);
        else pass_cnt++;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        total_cnt++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004 || inst_valid !== 1'b0)
            $display("[TB] FAIL basic_next: got v=%b a=%h iv=%b want 1/80000004/0", imem_req_valid, imem_req_addr, inst_valid);
        else pass_cnt++;
    endtask

    task automatic test_hold_stall();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0093;
        step();
        imem_rsp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (inst_valid !== 1'b1 || inst !== 32'h0010_0093 || inst_pc !== 32'h8000_0004 || imem_req_valid !== 1'b0)
                $display("[TB] FAIL hold_stable[%0d]: got v=%b i=%h pc=%h rv=%b want 1/00100093/80000004/0", i, inst_valid, inst, inst_pc, imem_req_valid);
            else pass_cnt++;
            step();
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        total_cnt++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0008)
            $display("[TB] FAIL hold_release: got v=%b a=%h want 1/80000008", imem_req_valid, imem_req_addr);
        else pass_cnt++;
    endtask

    task automatic test_rsp_err();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF; imem_rsp_err = 1'b1;
        step();
        imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
        total_cnt++;
        if (inst_valid !== 1'b1 || inst_fault !== 1'b1 || inst !== 32'h0 || inst_pc !== 32'h8000_0008)
            $display("[TB] FAIL rsp_err: got v=%b f=%b i=%h pc=%h want 1/1/00000000/80000008", inst_valid, inst_fault, inst, inst_pc);
        else pass_cnt++;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        total_cnt++;
        if (imem_req_addr !== 32'h8000_000C || imem_req_valid !== 1'b1) $display("[TB] FAIL err_next: got v=%b a=%h want 1/8000000c", imem_req_valid, imem_req_addr);
        else pass_cnt++;
    endtask

    task automatic test_redirect_wait();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
        step();
        redirect_valid = 1'b0;
        total_cnt++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) $display("[TB] FAIL redir_wait_idle: got rv=%b iv=%b want 0/0", imem_req_valid, inst_valid);
        else pass_cnt++;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBADB_AD00;
        step();
        imem_rsp_valid = 1'b0;
        total_cnt++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100)
            $display("[TB] FAIL redir_drop: got iv=%b rv=%b a=%h want 0/1/80000100", inst_valid, imem_req_valid, imem_req_addr);
        else pass_cnt++;
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0073;
        step();
        imem_rsp_valid = 1'b0;
        total_cnt++;
        if (inst_valid !== 1'b1 || inst !== 32'h0000_0073 || inst_pc !== 32'h8000_0100)
            $display("[TB] FAIL redir_target: got v=%b i=%h pc=%h want 1/00000073/80000100", inst_valid, inst, inst_pc);
        else pass_cnt++;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
    endtask

    task automatic test_redirect_misaligned();
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
        step();
        redirect_valid = 1'b0;
        total_cnt++;
        if (imem_req_valid !== 1'b0) $display("[TB] FAIL misalign_noreq: got %b want 0", imem_req_valid);
        else pass_cnt++;
        step();
        total_cnt++;
        if (inst_valid !== 1'b1 || inst_fault !== 1'b1 || inst !== 32'h0 || inst_pc !== 32'h8000_0102 || imem_req_valid !== 1'b0)
            $display("[TB] FAIL misalign_fault: got v=%b f=%b i=%h pc=%h rv=%b want 1/1/00000000/80000102/0", inst_valid, inst_fault, inst, inst_pc, imem_req_valid);
        else pass_cnt++;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
        step();
        redirect_valid = 1'b0;
        total_cnt++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0200)
            $display("[TB] FAIL hold_redirect: got iv=%b rv=%b a=%h want 0/1/80000200", inst_valid, imem_req_valid, imem_req_addr);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [2];
        words[0] = 32'h0020_0113;
        words[1] = 32'h0030_0193;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            imem_rsp_valid = 1'b1; imem_rsp_data = words[i];
            step();
            imem_rsp_valid = 1'b0;
            total_cnt++;
            if (inst_valid !== 1'b1 || inst !== words[i] || inst_pc !== 32'h8000_0200 + 32'(4 * i))
                $display("[TB] FAIL b2b_inst[%0d]: got v=%b i=%h pc=%h want 1/%h/%h", i, inst_valid, inst, inst_pc, words[i], 32'h8000_0200 + 32'(4 * i));
            else pass_cnt++;
            step();
            total_cnt++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0204 + 32'(4 * i))
                $display("[TB] FAIL b2b_req[%0d]: got v=%b a=%h want 1/%h", i, imem_req_valid, imem_req_addr, 32'h8000_0204 + 32'(4 * i));
            else pass_cnt++;
        end
        imem_req_ready = 1'b0;
        inst_ready = 1'b0;
    endtask

    task automatic test_halt();
`ifdef YSYX_25040105_IFU_PERF_EN
        logic [31:0] fetch_snap, stall_snap;
`endif
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        halt = 1'b1;
        step();
        halt = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0073;
        step();
        imem_rsp_valid = 1'b0;
`ifdef YSYX_25040105_IFU_PERF_EN
        total_cnt++;
        if (perf_fetch_cnt !== 32'd6) $display("[TB] FAIL perf_fetch: got %0d want 6", perf_fetch_cnt);
        else pass_cnt++;
        fetch_snap = perf_fetch_cnt;
        stall_snap = perf_stall_cnt;
`endif
        imem_req_ready = 1'b1; inst_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
        for (int i = 0; i < 6; i++) begin
            total_cnt++;
            if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0)
                $display("[TB] FAIL halt_quiet[%0d]: got rv=%b iv=%b want 0/0", i, imem_req_valid, inst_valid);
            else pass_cnt++;
            step();
        end
        imem_req_ready = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
`ifdef YSYX_25040105_IFU_PERF_EN
        total_cnt++;
        if (perf_fetch_cnt !== fetch_snap || perf_stall_cnt !== stall_snap)
            $display("[TB] FAIL perf_freeze: got %h/%h want %h/%h", perf_fetch_cnt, perf_stall_cnt, fetch_snap, stall_snap);
        else pass_cnt++;
`endif
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        total_cnt++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000)
            $display("[TB] FAIL halt_reset: got v=%b a=%h want 1/80000000", imem_req_valid, imem_req_addr);
        else pass_cnt++;
    endtask

    task automatic test_reset_midflight();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || imem_req_addr !== 32'h8000_0000)
            $display("[TB] FAIL async_reset: got rv=%b iv=%b a=%h want 0/0/80000000", imem_req_valid, inst_valid, imem_req_addr);
        else pass_cnt++;
        step();
        rst_n = 1'b1;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
        step();
        step();
        imem_rsp_valid = 1'b0;
        total_cnt++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000)
            $display("[TB] FAIL stale_rsp: got iv=%b rv=%b a=%h want 0/1/80000000", inst_valid, imem_req_valid, imem_req_addr);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_hold_stall();
        test_rsp_err();
        test_redirect_wait();
        test_redirect_misaligned();
        test_back_to_back();
        test_halt();
        test_reset_midflight();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
